// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, panel timing sets and colour constants for the LCD timing generator
package lcd_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lcd_state_e;

  typedef struct packed {
    logic [10:0] h_sync;
    logic [10:0] h_back;
    logic [10:0] h_disp;
    logic [10:0] h_front;
    logic [10:0] v_sync;
    logic [10:0] v_back;
    logic [10:0] v_disp;
    logic [10:0] v_front;
  } lcd_timing_t;

  // 4.3" 480x272 panel (the fixed timing of the previous driver)
  localparam lcd_timing_t LCD_TIMING_4P3 = '{
    h_sync: 11'd41, h_back: 11'd2,  h_disp: 11'd480, h_front: 11'd2,
    v_sync: 11'd10, v_back: 11'd2,  v_disp: 11'd272, v_front: 11'd2
  };

  // 7" 800x480 panel
  localparam lcd_timing_t LCD_TIMING_7P0 = '{
    h_sync: 11'd128, h_back: 11'd88, h_disp: 11'd800, h_front: 11'd40,
    v_sync: 11'd2,   v_back: 11'd33, v_disp: 11'd480, v_front: 11'd10
  };

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] BLACK   = 24'h000000;

  // MSB replication keeps full-scale 565 values at full-scale 888
  function automatic logic [23:0] expand_565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// rtl/lcd_pattern_gen.sv - eight vertical colour bars, bar position restarted at every line start
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_DISP = 480,
  parameter int CNT_W  = 11
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic        pix_en,
  output logic [23:0] bar_rgb
);

  localparam int BAR_W = H_DISP / 8;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  if (BAR_W < 1) begin : g_err_bar
    $error("lcd_pattern_gen: H_DISP must be at least 8");
  end

  logic [CNT_W-1:0] bar_cnt;
  logic [2:0]       bar_idx;

  // The last bar never advances, so it absorbs the H_DISP % 8 remainder
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (line_start) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (pix_en && (bar_idx != 3'd7)) begin
      if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bar_rgb = BLACK;
    case (bar_idx)
      3'd0:    bar_rgb = WHITE;
      3'd1:    bar_rgb = YELLOW;
      3'd2:    bar_rgb = CYAN;
      3'd3:    bar_rgb = GREEN;
      3'd4:    bar_rgb = MAGENTA;
      3'd5:    bar_rgb = RED;
      3'd6:    bar_rgb = BLUE;
      default: bar_rgb = BLACK;
    endcase
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - parametrised RGB parallel-LCD timing generator and pixel formatter
// Define LCD_TEST_PATTERN_EN to add the pat_sel input and the colour-bar source.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_SYNC  = int'(LCD_TIMING_4P3.h_sync),
  parameter int H_BACK  = int'(LCD_TIMING_4P3.h_back),
  parameter int H_DISP  = int'(LCD_TIMING_4P3.h_disp),
  parameter int H_FRONT = int'(LCD_TIMING_4P3.h_front),
  parameter int V_SYNC  = int'(LCD_TIMING_4P3.v_sync),
  parameter int V_BACK  = int'(LCD_TIMING_4P3.v_back),
  parameter int V_DISP  = int'(LCD_TIMING_4P3.v_disp),
  parameter int V_FRONT = int'(LCD_TIMING_4P3.v_front),
  parameter int CNT_W   = 11,
  parameter int REQ_LAT = 1,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fmt_565,
`ifdef LCD_TEST_PATTERN_EN
  input  logic             pat_sel,
`endif
  input  logic [23:0]      data_in,
  output logic             data_req,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             lcd_clk,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [23:0]      lcd_rgb,
  output logic             frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  if (REQ_LAT < 0 || REQ_LAT > 4) begin : g_err_lat
    $error("lcd_timing_gen: REQ_LAT must be in 0..4");
  end
  if (REQ_LAT > HA) begin : g_err_lat_ha
    $error("lcd_timing_gen: REQ_LAT exceeds H_SYNC+H_BACK");
  end
  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_err_cnt
    $error("lcd_timing_gen: totals do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] DE_H_BEG  = CNT_W'(HA);
  localparam logic [CNT_W-1:0] DE_H_END  = CNT_W'(HA + H_DISP);
  localparam logic [CNT_W-1:0] REQ_H_BEG = CNT_W'(HA - REQ_LAT);
  localparam logic [CNT_W-1:0] REQ_H_END = CNT_W'(HA - REQ_LAT + H_DISP);
  localparam logic [CNT_W-1:0] DE_V_BEG  = CNT_W'(VA);
  localparam logic [CNT_W-1:0] DE_V_END  = CNT_W'(VA + V_DISP);

  lcd_state_e       state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic h_last, v_last;
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // en is only honoured on the last cycle of a frame, so frames are never truncated
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (en) state <= ST_RUN;
        end
        ST_RUN: begin
          if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
              v_cnt <= '0;
              if (!en) state <= ST_IDLE;
            end else begin
              v_cnt <= v_cnt + 1'b1;
            end
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic run, v_win, de_now, req_now, hs_now, vs_now, fs_now;
  assign run     = (state == ST_RUN);
  assign v_win   = (v_cnt >= DE_V_BEG) && (v_cnt < DE_V_END);
  assign de_now  = run && v_win && (h_cnt >= DE_H_BEG) && (h_cnt < DE_H_END);
  assign req_now = run && v_win && (h_cnt >= REQ_H_BEG) && (h_cnt < REQ_H_END);
  assign hs_now  = run && (h_cnt < HS_END);
  assign vs_now  = run && (v_cnt < VS_END);
  assign fs_now  = run && (h_cnt == '0) && (v_cnt == '0);

  // Requests lead the display window by REQ_LAT so the source latency is hidden
  assign data_req = req_now;
  assign pixel_x  = req_now ? (h_cnt - REQ_H_BEG) : '0;
  assign pixel_y  = req_now ? (v_cnt - DE_V_BEG) : '0;
  assign lcd_clk  = lcd_pclk;

  logic [23:0] fmt_pix, src_pix;
  assign fmt_pix = fmt_565 ? expand_565(data_in[15:0]) : data_in;

`ifdef LCD_TEST_PATTERN_EN
  logic        pat_q;
  logic [23:0] bar_rgb;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n)      pat_q <= 1'b0;
    else if (fs_now) pat_q <= pat_sel;
  end

  lcd_pattern_gen #(
    .H_DISP (H_DISP),
    .CNT_W  (CNT_W)
  ) u_pattern (
    .lcd_pclk   (lcd_pclk),
    .rst_n      (rst_n),
    .line_start (h_cnt == '0),
    .pix_en     (de_now),
    .bar_rgb    (bar_rgb)
  );

  assign src_pix = pat_q ? bar_rgb : fmt_pix;
`else
  assign src_pix = fmt_pix;
`endif

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_hs      <= ~HS_POL;
      lcd_vs      <= ~VS_POL;
      lcd_de      <= 1'b0;
      lcd_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      lcd_hs      <= hs_now ? HS_POL : ~HS_POL;
      lcd_vs      <= vs_now ? VS_POL : ~VS_POL;
      lcd_de      <= de_now;
      lcd_rgb     <= de_now ? src_pix : '0;
      frame_start <= fs_now;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - directed bench for lcd_timing_gen on a reduced panel geometry
// Exercises the colour-bar source when LCD_TEST_PATTERN_EN is defined.
module tb_lcd_timing_gen;

  localparam int H_SYNC_T = 4, H_BACK_T = 3, H_DISP_T = 18, H_FRONT_T = 2;
  localparam int V_SYNC_T = 2, V_BACK_T = 1, V_DISP_T = 3,  V_FRONT_T = 2;
  localparam int CW = 8, LAT = 2;
  localparam bit HP = 1'b1, VP = 1'b0;
  localparam int HT = H_SYNC_T + H_BACK_T + H_DISP_T + H_FRONT_T;  // 27
  localparam int VT = V_SYNC_T + V_BACK_T + V_DISP_T + V_FRONT_T;  // 8
  localparam int HA = H_SYNC_T + H_BACK_T;                         // 7
  localparam int VA = V_SYNC_T + V_BACK_T;                         // 3
  localparam int FT = HT * VT;                                     // 216

  logic          lcd_pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fmt_565 = 1'b0;
`ifdef LCD_TEST_PATTERN_EN
  logic          pat_sel = 1'b0;
`endif
  logic [23:0]   data_in;
  logic          data_req;
  logic [CW-1:0] pixel_x, pixel_y;
  logic          lcd_clk, lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [23:0]   lcd_rgb;

  int errors = 0;
  int checks = 0;

  logic          use_fixed = 1'b0;
  logic [23:0]   fixed_data = 24'h0;
  logic          p1_req = 1'b0, p2_req = 1'b0;
  logic [CW-1:0] p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;

  lcd_timing_gen #(
    .H_SYNC (H_SYNC_T), .H_BACK (H_BACK_T), .H_DISP (H_DISP_T), .H_FRONT (H_FRONT_T),
    .V_SYNC (V_SYNC_T), .V_BACK (V_BACK_T), .V_DISP (V_DISP_T), .V_FRONT (V_FRONT_T),
    .CNT_W  (CW), .REQ_LAT (LAT), .HS_POL (HP), .VS_POL (VP)
  ) dut (
    .lcd_pclk    (lcd_pclk),
    .rst_n       (rst_n),
    .en          (en),
    .fmt_565     (fmt_565),
`ifdef LCD_TEST_PATTERN_EN
    .pat_sel     (pat_sel),
`endif
    .data_in     (data_in),
    .data_req    (data_req),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .lcd_clk     (lcd_clk),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_de      (lcd_de),
    .lcd_rgb     (lcd_rgb),
    .frame_start (frame_start)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  // Source model: answers each request with its own coordinate LAT cycles later
  always @(posedge lcd_pclk) begin
    p1_req <= data_req; p1_x <= pixel_x; p1_y <= pixel_y;
    p2_req <= p1_req;   p2_x <= p1_x;    p2_y <= p1_y;
  end
  assign data_in = use_fixed ? fixed_data : (p2_req ? {8'hA5, p2_y, p2_x} : 24'h0);

  task automatic tick;
    @(posedge lcd_pclk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0;
    repeat (3) tick;
    checks++; if (lcd_hs !== ~HP) begin errors++; $display("FAIL reset_hs: got %b expected %b", lcd_hs, ~HP); end
    checks++; if (lcd_vs !== ~VP) begin errors++; $display("FAIL reset_vs: got %b expected %b", lcd_vs, ~VP); end
    checks++; if (lcd_de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", lcd_de); end
    checks++; if (lcd_rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", lcd_rgb); end
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", data_req); end
    checks++; if (pixel_x !== '0 || pixel_y !== '0) begin errors++; $display("FAIL reset_pixel: got %0d,%0d expected 0,0", pixel_x, pixel_y); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    rst_n = 1'b1;
    repeat (5) tick;
    checks++; if (lcd_hs !== ~HP || lcd_de !== 1'b0 || frame_start !== 1'b0 || data_req !== 1'b0) begin
      errors++; $display("FAIL idle_outputs: got hs=%b de=%b fs=%b req=%b expected %b,0,0,0", lcd_hs, lcd_de, frame_start, data_req, ~HP);
    end
  endtask

  task automatic test_frame;
    int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, req_cnt = 0;
    en = 1'b1;
    tick;
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL start_fs_early: got %b expected 0", frame_start); end
    tick;
    for (int i = 0; i < FT; i++) begin
      int h, v, j, jh, jv;
      logic e_de, e_req, e_hs, e_vs;
      logic [23:0] e_rgb;
      logic [CW-1:0] e_px, e_py;
      h = i % HT; v = i / HT;
      j = (i + 1) % FT; jh = j % HT; jv = j / HT;
      e_hs  = (h < H_SYNC_T) ? HP : ~HP;
      e_vs  = (v < V_SYNC_T) ? VP : ~VP;
      e_de  = (h >= HA) && (h < HA + H_DISP_T) && (v >= VA) && (v < VA + V_DISP_T);
      e_rgb = e_de ? {8'hA5, 8'(v - VA), 8'(h - HA)} : 24'h0;
      e_req = (jh >= HA - LAT) && (jh < HA - LAT + H_DISP_T) && (jv >= VA) && (jv < VA + V_DISP_T);
      e_px  = e_req ? CW'(jh - (HA - LAT)) : '0;
      e_py  = e_req ? CW'(jv - VA) : '0;
      checks++; if (frame_start !== (i == 0)) begin errors++; $display("FAIL frame_fs i=%0d: got %b expected %b", i, frame_start, (i == 0)); end
      checks++; if (lcd_hs !== e_hs) begin errors++; $display("FAIL frame_hs i=%0d: got %b expected %b", i, lcd_hs, e_hs); end
      checks++; if (lcd_vs !== e_vs) begin errors++; $display("FAIL frame_vs i=%0d: got %b expected %b", i, lcd_vs, e_vs); end
      checks++; if (lcd_de !== e_de) begin errors++; $display("FAIL frame_de i=%0d: got %b expected %b", i, lcd_de, e_de); end
      checks++; if (lcd_rgb !== e_rgb) begin errors++; $display("FAIL frame_rgb i=%0d: got %h expected %h", i, lcd_rgb, e_rgb); end
      checks++; if (data_req !== e_req) begin errors++; $display("FAIL frame_req i=%0d: got %b expected %b", i, data_req, e_req); end
      checks++; if (pixel_x !== e_px) begin errors++; $display("FAIL frame_px i=%0d: got %0d expected %0d", i, pixel_x, e_px); end
      checks++; if (pixel_y !== e_py) begin errors++; $display("FAIL frame_py i=%0d: got %0d expected %0d", i, pixel_y, e_py); end
      if (lcd_hs === HP) hs_cnt++;
      if (lcd_vs === VP) vs_cnt++;
      if (lcd_de === 1'b1) de_cnt++;
      if (data_req === 1'b1) req_cnt++;
      tick;
    end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_period: got fs=%b expected 1 after %0d cycles", frame_start, FT); end
    checks++; if (hs_cnt != H_SYNC_T * VT) begin errors++; $display("FAIL hs_total: got %0d expected %0d", hs_cnt, H_SYNC_T * VT); end
    checks++; if (vs_cnt != V_SYNC_T * HT) begin errors++; $display("FAIL vs_total: got %0d expected %0d", vs_cnt, V_SYNC_T * HT); end
    checks++; if (de_cnt != H_DISP_T * V_DISP_T) begin errors++; $display("FAIL de_total: got %0d expected %0d", de_cnt, H_DISP_T * V_DISP_T); end
    checks++; if (req_cnt != H_DISP_T * V_DISP_T) begin errors++; $display("FAIL req_total: got %0d expected %0d", req_cnt, H_DISP_T * V_DISP_T); end
  endtask

  task automatic test_fmt;
    logic [23:0] vin  [5] = '{24'h00F800, 24'h008410, 24'h00FFFF, 24'hAB001F, 24'h123456};
    logic        vfmt [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [23:0] vexp [5] = '{24'hFF0000, 24'h848284, 24'hFFFFFF, 24'h0000FF, 24'h123456};
    use_fixed = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      fixed_data = vin[k]; fmt_565 = vfmt[k];
      tick;
      while (lcd_de !== 1'b1 && n < 2 * FT) begin tick; n++; end
      checks++;
      if (n >= 2 * FT) begin errors++; $display("FAIL fmt_timeout k=%0d: no lcd_de within %0d cycles", k, 2 * FT); end
      else if (lcd_rgb !== vexp[k]) begin errors++; $display("FAIL fmt k=%0d: got %h expected %h", k, lcd_rgb, vexp[k]); end
    end
    use_fixed = 1'b0; fmt_565 = 1'b0;
  endtask

  task automatic test_en_drop;
    int n = 0;
    int act = 0;
    while (frame_start !== 1'b1 && n < 2 * FT) begin tick; n++; end
    checks++; if (n >= 2 * FT) begin errors++; $display("FAIL endrop_sync: no frame_start within %0d cycles", 2 * FT); end
    repeat (4 * HT) tick;
    en = 1'b0;
    repeat ((VT - 1) * HT - 4 * HT) tick;
    checks++; if (lcd_hs !== HP) begin errors++; $display("FAIL endrop_last_line_hs: got %b expected %b", lcd_hs, HP); end
    repeat (FT - (VT - 1) * HT) tick;
    checks++; if (frame_start !== 1'b0 || lcd_hs !== ~HP || lcd_vs !== ~VP || data_req !== 1'b0) begin
      errors++; $display("FAIL endrop_idle: got fs=%b hs=%b vs=%b req=%b expected 0,%b,%b,0", frame_start, lcd_hs, lcd_vs, data_req, ~HP, ~VP);
    end
    for (int i = 0; i < 2 * FT; i++) begin
      if (frame_start === 1'b1 || lcd_de === 1'b1 || lcd_hs === HP || lcd_vs === VP || data_req === 1'b1) act++;
      tick;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL endrop_quiet: got %0d active cycles expected 0", act); end
    en = 1'b1;
    tick;
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL restart_fs_early: got %b expected 0", frame_start); end
    tick;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL restart_fs: got %b expected 1", frame_start); end
  endtask

  task automatic test_back_to_back;
    repeat (50) tick;
    en = 1'b0;
    repeat (FT - 2 - 50) tick;
    en = 1'b1;
    tick;
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL b2b_fs_early: got %b expected 0", frame_start); end
    tick;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL b2b_fs: got %b expected 1", frame_start); end
  endtask

  task automatic test_reset_mid_line;
    int n = 0;
    while (lcd_de !== 1'b1 && n < 2 * FT) begin tick; n++; end
    checks++; if (n >= 2 * FT) begin errors++; $display("FAIL rst_mid_sync: no lcd_de within %0d cycles", 2 * FT); end
    repeat (3) tick;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (lcd_hs !== ~HP || lcd_vs !== ~VP) begin errors++; $display("FAIL rst_mid_sync_pins: got hs=%b vs=%b expected %b,%b", lcd_hs, lcd_vs, ~HP, ~VP); end
    checks++; if (lcd_de !== 1'b0 || lcd_rgb !== 24'h0) begin errors++; $display("FAIL rst_mid_de_rgb: got de=%b rgb=%h expected 0,000000", lcd_de, lcd_rgb); end
    checks++; if (data_req !== 1'b0 || pixel_x !== '0 || pixel_y !== '0 || frame_start !== 1'b0) begin
      errors++; $display("FAIL rst_mid_req: got req=%b x=%0d y=%0d fs=%b expected 0,0,0,0", data_req, pixel_x, pixel_y, frame_start);
    end
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_restart_fs_early: got %b expected 0", frame_start); end
    tick;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_restart_fs: got %b expected 1", frame_start); end
    n = 0;
    while (lcd_de !== 1'b1 && n < FT) begin tick; n++; end
    checks++; if (n != VA * HT + HA) begin errors++; $display("FAIL rst_first_de: got %0d cycles expected %0d", n, VA * HT + HA); end
    while (frame_start !== 1'b1 && n < 2 * FT) begin tick; n++; end
    checks++; if (n != FT) begin errors++; $display("FAIL rst_frame_len: got %0d cycles expected %0d", n, FT); end
  endtask

`ifdef LCD_TEST_PATTERN_EN
  task automatic test_pattern;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int n = 0;
    pat_sel = 1'b1;
    tick;
    while (frame_start !== 1'b1 && n < 2 * FT) begin tick; n++; end
    n = 0;
    while (lcd_de !== 1'b1 && n < 2 * FT) begin tick; n++; end
    checks++; if (n >= 2 * FT) begin errors++; $display("FAIL pat_sync: no lcd_de within %0d cycles", 2 * FT); end
    for (int k = 0; k < H_DISP_T; k++) begin
      int idx;
      idx = (k / (H_DISP_T / 8) > 7) ? 7 : k / (H_DISP_T / 8);
      checks++; if (lcd_rgb !== bars[idx] || lcd_de !== 1'b1) begin
        errors++; $display("FAIL pat_pixel k=%0d: got de=%b rgb=%h expected 1,%h", k, lcd_de, lcd_rgb, bars[idx]);
      end
      tick;
    end
    pat_sel = 1'b0;
    n = 0;
    while (lcd_de !== 1'b1 && n < 2 * FT) begin tick; n++; end
    checks++; if (lcd_rgb !== 24'hFFFFFF) begin errors++; $display("FAIL pat_hold: got %h expected FFFFFF", lcd_rgb); end
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FT) begin tick; n++; end
    n = 0;
    while (lcd_de !== 1'b1 && n < 2 * FT) begin tick; n++; end
    checks++; if (lcd_rgb !== 24'hA50000) begin errors++; $display("FAIL pat_release: got %h expected A50000", lcd_rgb); end
  endtask
`endif

  initial begin
    test_reset;
    test_frame;
    test_fmt;
    test_en_drop;
    test_back_to_back;
    test_reset_mid_line;
`ifdef LCD_TEST_PATTERN_EN
    test_pattern;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised RGB parallel-LCD timing generator and pixel formatter; successor to the fixed 480x272 LCD driver. Generates HS/VS/DE from configurable porch and sync widths, requests pixels ahead of display by a configurable latency, and formats RGB565 or RGB888 source data onto a registered 24-bit bus. It sits between the frame-buffer reader (SD/DDR image path) and the LCD pins, and adds frame-boundary start/stop control.

## Interface
- H_SYNC, 41, HS pulse width in pclk cycles
- H_BACK, 2, horizontal back porch
- H_DISP, 480, active pixels per line
- H_FRONT, 2, horizontal front porch
- V_SYNC, 10, VS pulse width in lines
- V_BACK, 2, vertical back porch
- V_DISP, 272, active lines
- V_FRONT, 2, vertical front porch
- CNT_W, 11, counter and coordinate width
- REQ_LAT, 1, cycles from data_req to valid data_in (0..4)
- HS_POL / VS_POL, 0, active level of lcd_hs / lcd_vs
- lcd_pclk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run request; sampled at frame boundary
- fmt_565  in  1  1: data_in[15:0] is RGB565; 0: data_in[23:0] is RGB888
- data_in  in  24  source pixel, valid REQ_LAT cycles after data_req
- data_req  out  1  pixel request strobe
- pixel_x / pixel_y  out  CNT_W  coordinate of requested pixel; 0 when data_req low
- lcd_clk  out  1  equals lcd_pclk
- lcd_hs / lcd_vs / lcd_de  out  1  registered sync and data enable
- lcd_rgb  out  24  registered pixel {R,G,B}; 0 when lcd_de low
- frame_start  out  1  one-cycle pulse at first cycle of each frame

## Operation
- Derived: H_TOTAL = sum of H params (525 default), V_TOTAL = sum of V params (286); HA = H_SYNC+H_BACK, VA = V_SYNC+V_BACK.
- Elaboration error if REQ_LAT > 4, REQ_LAT > HA, or H_TOTAL/V_TOTAL ≥ 2^CNT_W.
- FSM IDLE/RUN. Reset -> IDLE. IDLE: h_cnt = v_cnt = 0, no outputs active. IDLE->RUN when en=1; counting begins next cycle from (0,0).
- RUN: h_cnt wraps at H_TOTAL-1; v_cnt increments on h wrap, wraps at V_TOTAL-1. At h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1: en=0 -> IDLE, else continue. en deassert mid-frame completes the frame; en re-assert in the last cycle keeps RUN with no gap.
- Active window: HA ≤ h_cnt < HA+H_DISP and VA ≤ v_cnt < VA+V_DISP.
- data_req: h_cnt window shifted earlier by REQ_LAT, same lines; pixel_x = h_cnt-(HA-REQ_LAT), pixel_y = v_cnt-VA. Exactly H_DISP*V_DISP requests per frame.
- RGB565 expansion by MSB replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}. RGB888 passes through.
- lcd_hs active when h_cnt < H_SYNC, lcd_vs active when v_cnt < V_SYNC, driven at HS_POL/VS_POL; inactive otherwise and in IDLE.

## Timing
- Reset values: lcd_hs = ~HS_POL, lcd_vs = ~VS_POL, lcd_de = 0, lcd_rgb = 0, data_req = 0, pixel_x/y = 0, frame_start = 0.
- All pin outputs registered: lcd_hs/vs/de/rgb and frame_start show counter state of previous cycle (1-cycle pipeline), mutually aligned.
- data_req for pixel k at cycle t; data_in sampled at end of cycle t+REQ_LAT; appears on lcd_rgb with lcd_de=1 at cycle t+REQ_LAT+1.
- frame_start coincides with first cycle of lcd_vs and lcd_hs active.
- Reset mid-line: all outputs to reset values immediately; restart from (0,0) after en.

## Configuration
- LCD_TEST_PATTERN_EN defined: adds input pat_sel (1 bit); pat_sel=1 replaces data_in with 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), each H_DISP/8 pixels wide (last bar takes remainder), same latency and DE alignment; data_req still issued. pat_sel changes take effect at next frame_start.
- Undefined: no pat_sel port, no pattern logic; lcd_rgb always from data_in.

## Structure
- Package lcd_pkg: FSM state enum, localparam timing sets for 4.3" 480x272 and 7" 800x480, colour constants (WHITE, BLACK, RED, GREEN, BLUE, ...).
- Sub-module lcd_pattern_gen (bar counter reset on line start, bar index), instantiated only under LCD_TEST_PATTERN_EN.

## Test plan
- Defaults, en=1: line period 525 cycles, lcd_hs active 41 cycles, frame 286 lines, lcd_vs active 10 lines, 130560 data_req per frame.
- REQ_LAT=2, data_in = {pixel_y,pixel_x} delayed 2: lcd_rgb equals expected coordinate on every lcd_de cycle; first DE at h_cnt=44 (registered).
- fmt_565=1, data_in 16'hF800 -> 24'hFF0000; 16'h8410 -> 24'h848284; 16'hFFFF -> 24'hFFFFFF.
- en dropped at line 100: frame completes to line 285, then IDLE; all outputs inactive; en re-raised -> frame_start one cycle after RUN entry.
- rst_n asserted mid-active-line: outputs to reset values asynchronously; after release and en, first frame timing identical to cold start.
- LCD_TEST_PATTERN_EN, pat_sel=1: pixels 0..59 = 24'hFFFFFF, 60..119 = 24'hFFFF00, 420..479 = 24'h000000.
